cache_controller: RTL and testbench

Direct-mapped, write-through, write-allocate controller between the 16-bit MIPS datapath and the 256x16 on-chip cache data array. It holds tag and valid storage, decides hit or miss, stalls the CPU, and runs a single-word req/ack handshake with the off-chip memory interface. Hits complete in the same cycle. Misses and all writes go to off-chip memory and are committed into the data array.

---
 rtl/cache_controller.sv | 146 ++++++++++++++
 tb/tb_cache_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, write-allocate cache controller.
// Owns tag/valid storage, resolves hits in IDLE with zero latency and sends misses
// and all writes through a single-word req/ack handshake to off-chip memory. Every
// off-chip transaction finishes with one COMMIT cycle that writes the data array.
module cache_controller #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned INDEX_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_rd,
    input  logic                cpu_wr,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                stall,
    output logic [INDEX_W-1:0]  cache_addr,
    output logic [DATA_W-1:0]   cache_wdata,
    output logic                cache_we,
    input  logic [DATA_W-1:0]   cache_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W;
    localparam int unsigned LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        StIdle,
        StMemRd,
        StMemWr,
        StCommit
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q [LINES];

    logic [INDEX_W-1:0]  cpu_index;
    logic [TAG_W-1:0]    cpu_tag;
    logic [INDEX_W-1:0]  lat_index;
    logic [TAG_W-1:0]    lat_tag;
    logic                hit;

    assign cpu_index = cpu_addr[INDEX_W-1:0];
    assign cpu_tag   = cpu_addr[ADDR_W-1:INDEX_W];
    assign lat_index = addr_q[INDEX_W-1:0];
    assign lat_tag   = addr_q[ADDR_W-1:INDEX_W];

    // Only meaningful in IDLE; other states never look at it.
    assign hit = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);

    // Off-chip address/data and array write data come straight from latched state.
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign cache_wdata = fill_q;

    // Next-state and output decode; request strobes depend on state_q only.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fill_d     = fill_q;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        cache_we   = 1'b0;
        cache_addr = cpu_index;
        cpu_rdata  = cache_rdata;
        case (state_q)
            StIdle: begin
                // A write takes priority over a simultaneous read.
                if (cpu_wr) begin
                    stall   = 1'b1;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = StMemWr;
                end else if (cpu_rd && !hit) begin
                    stall   = 1'b1;
                    addr_d  = cpu_addr;
                    state_d = StMemRd;
                end
            end
            StMemRd: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    fill_d  = mem_rdata;
                    state_d = StCommit;
                end
            end
            StMemWr: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    fill_d  = wdata_q;
                    state_d = StCommit;
                end
            end
            StCommit: begin
                // CPU retires here; its request lines are ignored this cycle.
                cache_we   = 1'b1;
                cache_addr = lat_index;
                cpu_rdata  = fill_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, latched request, fill buffer and valid bits with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            fill_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fill_q  <= fill_d;
            if (state_q == StCommit) begin
                valid_q[lat_index] <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: an entry is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StCommit) begin
            tag_q[lat_index] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: a transaction-level cache model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall;
    logic [7:0]  cache_addr;
    logic [15:0] cache_wdata, cache_rdata;
    logic        cache_we;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    cache_controller #(.ADDR_W(16), .DATA_W(16), .INDEX_W(8)) dut (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we),
        .cache_rdata(cache_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Data array environment: combinational read, write on posedge.
    logic [15:0] dmem [256];
    assign cache_rdata = dmem[cache_addr];
    always @(posedge clk) if (cache_we) dmem[cache_addr] <= cache_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    // Cache contents as the CPU should see them, and the one outstanding transaction.
    bit          m_valid [256];
    logic [7:0]  m_tag   [256];
    logic [15:0] m_data  [256];
    int          m_ph = 0;      // 0: none outstanding, 1: waiting on memory, 2: retiring
    bit          m_wr;
    logic [15:0] m_addr, m_wdata, m_fill;

    function automatic bit m_hit(input logic [15:0] a);
        return m_valid[a[7:0]] && (m_tag[a[7:0]] == a[15:8]);
    endfunction

    initial for (int i = 0; i < 256; i++) begin m_valid[i] = 0; m_tag[i] = '0; end

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0;
            for (int i = 0; i < 256; i++) m_valid[i] = 0;
        end else begin
            case (m_ph)
                0: if (cpu_wr) begin
                       m_ph = 1; m_wr = 1; m_addr = cpu_addr; m_wdata = cpu_wdata;
                   end else if (cpu_rd && !m_hit(cpu_addr)) begin
                       m_ph = 1; m_wr = 0; m_addr = cpu_addr;
                   end
                1: if (mem_ack) begin
                       m_fill = m_wr ? m_wdata : mem_rdata;
                       m_ph = 2;
                   end
                default: begin
                    m_valid[m_addr[7:0]] = 1;
                    m_tag[m_addr[7:0]]   = m_addr[15:8];
                    m_data[m_addr[7:0]]  = m_fill;
                    m_ph = 0;
                end
            endcase
        end
    end

    // Compare DUT outputs with the model mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            case (m_ph)
                0: begin
                    chk("m_stall", stall, cpu_wr || (cpu_rd && !m_hit(cpu_addr)));
                    chk("m_mem_req", mem_req, 0);
                    chk("m_cache_we", cache_we, 0);
                    chk("m_cache_addr", cache_addr, cpu_addr[7:0]);
                    if (cpu_rd && !cpu_wr && m_hit(cpu_addr))
                        chk("m_hit_rdata", cpu_rdata, m_data[cpu_addr[7:0]]);
                end
                1: begin
                    chk("m_stall", stall, 1);
                    chk("m_mem_req", mem_req, 1);
                    chk("m_mem_we", mem_we, m_wr);
                    chk("m_mem_addr", mem_addr, m_addr);
                    chk("m_cache_we", cache_we, 0);
                    if (m_wr) chk("m_mem_wdata", mem_wdata, m_wdata);
                end
                default: begin
                    chk("m_stall", stall, 0);
                    chk("m_mem_req", mem_req, 0);
                    chk("m_cache_we", cache_we, 1);
                    chk("m_cache_addr", cache_addr, m_addr[7:0]);
                    chk("m_cache_wdata", cache_wdata, m_fill);
                    chk("m_cpu_rdata", cpu_rdata, m_fill);
                end
            endcase
        end
    end

    // ---------------- directed stimulus ----------------
    int          r_nst, r_nrd, r_nwr;
    logic [15:0] r_rdata, r_cwd, r_maddr, r_mwd;
    logic [7:0]  r_caddr;
    logic        r_we;

    // Advance to just after the next posedge and drop the CPU request.
    task automatic step();
        @(posedge clk); #1;
        cpu_rd = 0; cpu_wr = 0; mem_ack = 0;
    endtask

    // Issue one access (called just after a posedge), acking on the ack_on-th memory
    // cycle; returns at the negedge of the cycle where stall is low (retire).
    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wd, input int ack_on, input logic [15:0] rdat);
        int mcyc = 0;
        bit done = 0;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
        r_nst = 0; r_nrd = 0; r_nwr = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req) begin
                mcyc++;
                mem_ack   = (mcyc == ack_on);
                mem_rdata = rdat;
            end else begin
                mem_ack = 0;
            end
            @(negedge clk);
            if (mem_req) begin
                r_maddr = mem_addr;
                if (mem_we) begin r_nwr++; r_mwd = mem_wdata; end
                else r_nrd++;
            end
            if (!stall) begin
                done = 1;
                r_rdata = cpu_rdata; r_we = cache_we; r_caddr = cache_addr; r_cwd = cache_wdata;
                break;
            end
            r_nst++;
            @(posedge clk); #1;
        end
        if (!done) chk("access_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_cache_we", cache_we, 0);
        step();

        // Miss at 0x1234, ack on third memory cycle
        access(1, 0, 16'h1234, 16'h0, 3, 16'hBEEF);
        chk("miss_stall_cycles", r_nst, 4);
        chk("miss_mem_rd_cycles", r_nrd, 3);
        chk("miss_mem_addr", r_maddr, 16'h1234);
        chk("miss_commit_we", r_we, 1);
        chk("miss_commit_addr", r_caddr, 8'h34);
        chk("miss_commit_wdata", r_cwd, 16'hBEEF);
        chk("miss_rdata", r_rdata, 16'hBEEF);
        step();

        // Re-read hits with zero latency
        access(1, 0, 16'h1234, 16'h0, 1, 16'h0);
        chk("hit_stall_cycles", r_nst, 0);
        chk("hit_no_mem", r_nrd + r_nwr, 0);
        chk("hit_rdata", r_rdata, 16'hBEEF);
        step();

        // Same index, different tag: conflict miss
        access(1, 0, 16'h5634, 16'h0, 1, 16'h1111);
        chk("conflict_stall_cycles", r_nst, 2);
        chk("conflict_rdata", r_rdata, 16'h1111);
        step();
        access(1, 0, 16'h1234, 16'h0, 1, 16'hBEEF);
        chk("evicted_miss_cycles", r_nst, 2);
        chk("evicted_rdata", r_rdata, 16'hBEEF);
        step();

        // Write-through with allocate
        access(0, 1, 16'h1234, 16'h00AA, 2, 16'hFFFF);
        chk("wr_stall_cycles", r_nst, 3);
        chk("wr_mem_wr_cycles", r_nwr, 2);
        chk("wr_mem_rd_cycles", r_nrd, 0);
        chk("wr_mem_wdata", r_mwd, 16'h00AA);
        chk("wr_commit_addr", r_caddr, 8'h34);
        chk("wr_commit_wdata", r_cwd, 16'h00AA);
        step();
        access(1, 0, 16'h1234, 16'h0, 1, 16'h0);
        chk("wr_then_hit_cycles", r_nst, 0);
        chk("wr_then_hit_rdata", r_rdata, 16'h00AA);
        step();

        // Simultaneous read and write: write path only
        access(1, 1, 16'h2001, 16'h5A5A, 1, 16'h0BAD);
        chk("rdwr_mem_rd_cycles", r_nrd, 0);
        chk("rdwr_mem_wr_cycles", r_nwr, 1);
        chk("rdwr_mem_addr", r_maddr, 16'h2001);
        chk("rdwr_commit_wdata", r_cwd, 16'h5A5A);
        step();

        // Reset in the middle of a memory read, then a late ack
        cpu_rd = 1; cpu_addr = 16'h0777;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; cpu_rd = 0; mem_ack = 1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        chk("rstmid_mem_req", mem_req, 0);
        chk("rstmid_stall", stall, 0);
        chk("rstmid_cache_we", cache_we, 0);
        @(posedge clk); #1;
        mem_ack = 0;
        @(negedge clk);
        chk("late_ack_mem_req", mem_req, 0);
        chk("late_ack_cache_we", cache_we, 0);
        @(posedge clk); #1;
        access(1, 0, 16'h1234, 16'h0, 1, 16'h4321);
        chk("post_rst_miss_cycles", r_nst, 2);
        chk("post_rst_rdata", r_rdata, 16'h4321);
        step();
        @(posedge clk); #1;

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
